// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the receive and transmit sides.
package spi_pkg;

   typedef enum logic {
      SAMPLE_RISE,
      SAMPLE_FALL
   } spi_mode_t;

   localparam int unsigned SPI_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spi_rx_if.sv
// Bus between the SPI receive deserializer and the pins / DAQ datapath.
interface spi_rx_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic             rx_en_i;
   logic             SCLK_i;
   logic             MISO_i;
   logic             rx_ack_i;
   logic             rx_clear_i;
   logic [WIDTH-1:0] rx_data_o;
   logic             rx_valid_o;
   logic             rx_overrun_o;
   logic             rx_busy_o;

   modport master (
      output rx_en_i, SCLK_i, MISO_i, rx_ack_i, rx_clear_i,
      input  rx_data_o, rx_valid_o, rx_overrun_o, rx_busy_o
   );

   modport slave (
      input  rx_en_i, SCLK_i, MISO_i, rx_ack_i, rx_clear_i,
      output rx_data_o, rx_valid_o, rx_overrun_o, rx_busy_o
   );

endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for SCLK and MISO with registered SCLK edge pulses.
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clock_i,
   input  logic reset_ni,
   input  logic sclk,
   input  logic miso,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic miso_sync
);

   logic [SYNC_STAGES-1:0] sclk_pipe;
   logic [SYNC_STAGES-1:0] miso_pipe;
   logic                   sclk_prev;

   // Edge pulses and miso_sync are registered together, so data stays aligned with its strobe.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         sclk_pipe <= '0;
         miso_pipe <= '0;
         sclk_prev <= 1'b0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         miso_sync <= 1'b0;
      end else begin
         sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
         miso_pipe <= {miso_pipe[SYNC_STAGES-2:0], miso};
         sclk_prev <= sclk_pipe[SYNC_STAGES-1];
         sclk_rise <= sclk_pipe[SYNC_STAGES-1] & ~sclk_prev;
         sclk_fall <= ~sclk_pipe[SYNC_STAGES-1] & sclk_prev;
         miso_sync <= miso_pipe[SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/spi_rx.sv
// SPI receive deserializer: assembles WIDTH-bit words from MISO and hands
// them to the DAQ datapath with valid/ack and a sticky overrun flag.
module spi_rx
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH         = 8,
   parameter bit          MSB_FIRST     = 1'b1,
   parameter bit          SAMPLE_RISING = 1'b1,
   parameter int unsigned SYNC_STAGES   = SPI_SYNC_STAGES_DEFAULT
) (
   input logic     clock_i,
   input logic     reset_ni,
   spi_rx_if.slave bus
);

   localparam spi_mode_t     MODE = SAMPLE_RISING ? SAMPLE_RISE : SAMPLE_FALL;
   localparam int unsigned   CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             sclk_rise;
   logic             sclk_fall;
   logic             miso_sync;
   logic             strobe;
   logic             complete;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] next_word;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             overrun_q;

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clock_i   (clock_i),
      .reset_ni  (reset_ni),
      .sclk      (bus.SCLK_i),
      .miso      (bus.MISO_i),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .miso_sync (miso_sync)
   );

   always_comb begin
      strobe    = (MODE == SAMPLE_RISE) ? sclk_rise : sclk_fall;
      next_word = MSB_FIRST ? {shift_q[WIDTH-2:0], miso_sync}
                            : {miso_sync, shift_q[WIDTH-1:1]};
      complete  = bus.rx_en_i & strobe & (count_q == LAST);
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         shift_q   <= '0;
         count_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (!bus.rx_en_i) begin
            shift_q <= '0;
            count_q <= '0;
         end else if (strobe) begin
            shift_q <= next_word;
            count_q <= complete ? '0 : count_q + 1'b1;
         end

         if (complete) begin
            data_q  <= next_word;
            valid_q <= 1'b1;
         end else if (valid_q && bus.rx_ack_i) begin
            valid_q <= 1'b0;
         end

         // A fresh overrun outranks a clear in the same cycle.
         if (complete && valid_q && !bus.rx_ack_i)
            overrun_q <= 1'b1;
         else if (bus.rx_clear_i)
            overrun_q <= 1'b0;
      end
   end

   assign bus.rx_data_o    = data_q;
   assign bus.rx_valid_o   = valid_q;
   assign bus.rx_overrun_o = overrun_q;
   assign bus.rx_busy_o    = bus.rx_en_i & (count_q != '0);

endmodule
